// File: rtl/package_sorter_param_pkg.sv
// Shared sorter types: default thresholds, FSM encoding
// and the weight-to-group classifier.
package pkg_sorter;

  localparam int MAX_TH = 8;

  localparam int unsigned DEF_THRESH [MAX_TH] = '{
    250, 500, 750, 1500, 2000, 2500, 3000, 3500
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    COUNTED
  } state_e;

  // Lowest matching index wins, so scan from the top down.
  function automatic int classify(
    input int unsigned w,
    input int unsigned th [MAX_TH],
    input int          n_grp
  );
    int g;
    g = n_grp;
    for (int k = MAX_TH; k >= 1; k--) begin
      if (k < n_grp && w <= th[k-1]) g = k;
    end
    if (w == 0) g = 0;
    return g;
  endfunction

endpackage

// File: rtl/package_sorter_param_if.sv
// Threshold programming bus between the host
// and the package sorter.
interface package_sorter_param_if #(
  parameter int W_WIDTH = 12,
  parameter int GRP_W   = 4
);
  logic               cfg_we;
  logic [GRP_W-1:0]   cfg_idx;
  logic [W_WIDTH-1:0] cfg_thresh;

  modport master (
    output cfg_we, cfg_idx, cfg_thresh
  );

  modport slave (
    input cfg_we, cfg_idx, cfg_thresh
  );
endinterface

// File: rtl/package_sorter_param_grp_counter.sv
// Per-group saturating package counter with
// clear and sticky saturation flag.
module sorter_grp_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 sat
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, base;
  logic                 sat_q, sat_d;

  // Clear lands first so a same-cycle count reads 1.
  always_comb begin
    base  = clr ? '0 : cnt_q;
    sat_d = clr ? 1'b0 : sat_q;
    cnt_d = base;
    if (inc) begin
      if (&base) sat_d = 1'b1;
      else       cnt_d = base + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/package_sorter_param.sv
// Package sorter: classifies a settled scale weight
// into programmable groups and counts each package once.
module package_sorter_param
  import pkg_sorter::*;
#(
  parameter int W_WIDTH   = 12,
  parameter int NUM_GRP   = 6,
  parameter int CNT_WIDTH = 8,
  parameter int SETTLE    = 2,
  parameter int GRP_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [W_WIDTH-1:0]           weight,
  package_sorter_param_if.slave        cfg,
  input  logic                         clear_counts,
  output logic [GRP_W-1:0]             current_grp,
  output logic                         count_evt,
  output logic [GRP_W-1:0]             count_grp,
  output logic [NUM_GRP*CNT_WIDTH-1:0] grp_count,
  output logic [NUM_GRP-1:0]           grp_sat
);

  localparam int NTH  = NUM_GRP - 1;
  localparam int SC_W = $clog2(SETTLE + 1);

  logic [W_WIDTH-1:0] thresh_q [NTH];
  logic [W_WIDTH-1:0] thresh_d [NTH];
  int unsigned        th_ext [MAX_TH];
  logic [GRP_W-1:0]   cls;

  state_e           state_q, state_d;
  logic [GRP_W-1:0] stab_grp_q, stab_grp_d;
  logic [SC_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic [GRP_W-1:0] cur_grp_q, cur_grp_d;
  logic             evt_q, evt_d;
  logic [GRP_W-1:0] evt_grp_q, evt_grp_d;
  logic             do_cnt;
  logic [GRP_W-1:0] cnt_sel;
  logic [NUM_GRP-1:0] inc;

  always_comb begin
    for (int i = 0; i < MAX_TH; i++) th_ext[i] = '0;
    for (int i = 0; i < NTH; i++)
      th_ext[i] = 32'(thresh_q[i]);
    cls = GRP_W'(classify(32'(weight), th_ext, NUM_GRP));
  end

  // Out-of-range indices match no slot and are dropped.
  always_comb begin
    thresh_d = thresh_q;
    for (int i = 0; i < NTH; i++) begin
      if (cfg.cfg_we && cfg.cfg_idx == GRP_W'(i))
        thresh_d[i] = cfg.cfg_thresh;
    end
  end

  always_comb begin
    state_d    = state_q;
    stab_grp_d = stab_grp_q;
    stab_cnt_d = stab_cnt_q;
    do_cnt     = 1'b0;
    cnt_sel    = '0;
    unique case (state_q)
      IDLE: begin
        if (cls != '0) begin
          if (SETTLE == 1) begin
            do_cnt  = 1'b1;
            cnt_sel = cls;
            state_d = COUNTED;
          end else begin
            state_d    = SETTLING;
            stab_grp_d = cls;
            stab_cnt_d = SC_W'(1);
          end
        end
      end
      SETTLING: begin
        if (cls == '0) begin
          state_d = IDLE;
        end else if (cls != stab_grp_q) begin
          stab_grp_d = cls;
          stab_cnt_d = SC_W'(1);
        end else if (int'(stab_cnt_q) + 1 == SETTLE) begin
          do_cnt  = 1'b1;
          cnt_sel = stab_grp_q;
          state_d = COUNTED;
        end else begin
          stab_cnt_d = stab_cnt_q + SC_W'(1);
        end
      end
      COUNTED: begin
        if (cls == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cur_grp_d = cls;
    evt_d     = do_cnt;
    evt_grp_d = do_cnt ? cnt_sel : '0;
    for (int k = 0; k < NUM_GRP; k++)
      inc[k] = do_cnt && (cnt_sel == GRP_W'(k + 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTH; i++)
        thresh_q[i] <= W_WIDTH'(DEF_THRESH[i]);
      state_q    <= IDLE;
      stab_grp_q <= '0;
      stab_cnt_q <= '0;
      cur_grp_q  <= '0;
      evt_q      <= 1'b0;
      evt_grp_q  <= '0;
    end else begin
      thresh_q   <= thresh_d;
      state_q    <= state_d;
      stab_grp_q <= stab_grp_d;
      stab_cnt_q <= stab_cnt_d;
      cur_grp_q  <= cur_grp_d;
      evt_q      <= evt_d;
      evt_grp_q  <= evt_grp_d;
    end
  end

  for (genvar k = 0; k < NUM_GRP; k++) begin : g_cnt
    sorter_grp_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clear_counts),
      .inc   (inc[k]),
      .cnt   (grp_count[k*CNT_WIDTH +: CNT_WIDTH]),
      .sat   (grp_sat[k])
    );
  end

  assign current_grp = cur_grp_q;
  assign count_evt   = evt_q;
  assign count_grp   = evt_grp_q;

endmodule

// File: tb/tb_package_sorter_param.sv
// Scenario bench for package_sorter_param with a
// run-length reference model and random traffic.
module tb_package_sorter_param;

  localparam int W      = 12;
  localparam int NG     = 6;
  localparam int CW     = 2;
  localparam int SETTLE = 2;
  localparam int GW     = 4;
  localparam int MAXC   = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [W-1:0]     weight;
  logic             clear_counts;
  logic [GW-1:0]    current_grp;
  logic             count_evt;
  logic [GW-1:0]    count_grp;
  logic [NG*CW-1:0] grp_count;
  logic [NG-1:0]    grp_sat;

  package_sorter_param_if #(.W_WIDTH(W), .GRP_W(GW)) cfg_if ();

  package_sorter_param #(
    .W_WIDTH   (W),
    .NUM_GRP   (NG),
    .CNT_WIDTH (CW),
    .SETTLE    (SETTLE),
    .GRP_W     (GW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .weight       (weight),
    .cfg          (cfg_if),
    .clear_counts (clear_counts),
    .current_grp  (current_grp),
    .count_evt    (count_evt),
    .count_grp    (count_grp),
    .grp_count    (grp_count),
    .grp_sat      (grp_sat)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  int th_m [8];
  int cnt_m [NG+1];
  bit sat_m [NG+1];
  int run_len, prev_c;
  bit counted;
  int exp_cur, exp_grp;
  bit exp_evt;

  int n_evt, last_grp;

  function automatic int cls_m(int w);
    if (w == 0) return 0;
    for (int k = 1; k < NG; k++)
      if (w <= th_m[k-1]) return k;
    return NG;
  endfunction

  function automatic int get_cnt(int k);
    return int'((grp_count >> ((k - 1) * CW)) & MAXC);
  endfunction

  // Advance model on current inputs, then clock the DUT.
  task automatic tick();
    int c;
    int dth [8];
    dth = '{250, 500, 750, 1500, 2000, 2500, 3000, 3500};
    if (reset) begin
      th_m = dth;
      for (int k = 0; k <= NG; k++) begin
        cnt_m[k] = 0;
        sat_m[k] = 0;
      end
      run_len = 0; prev_c = 0; counted = 0;
      exp_cur = 0; exp_evt = 0; exp_grp = 0;
    end else begin
      c = cls_m(int'(weight));
      exp_cur = c; exp_evt = 0; exp_grp = 0;
      if (c == 0) begin
        run_len = 0;
        counted = 0;
      end else begin
        run_len = (c == prev_c) ? run_len + 1 : 1;
        if (!counted && run_len == SETTLE) begin
          exp_evt = 1; exp_grp = c; counted = 1;
        end
      end
      prev_c = c;
      if (clear_counts)
        for (int k = 0; k <= NG; k++) begin
          cnt_m[k] = 0;
          sat_m[k] = 0;
        end
      if (exp_evt) begin
        if (cnt_m[c] == MAXC) sat_m[c] = 1;
        else cnt_m[c]++;
      end
      if (cfg_if.cfg_we && int'(cfg_if.cfg_idx) <= NG - 2)
        th_m[cfg_if.cfg_idx] = int'(cfg_if.cfg_thresh);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int w, input int n);
    weight = W'(w);
    repeat (n) begin
      tick();
      if (count_evt === 1'b1) begin
        n_evt++;
        last_grp = int'(count_grp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; weight = '0; clear_counts = 0;
    cfg_if.cfg_we = 0; cfg_if.cfg_idx = '0;
    cfg_if.cfg_thresh = '0;
    tick(); tick();
    checks++;
    if (current_grp !== '0) begin
      errors++;
      $display("FAIL rst_cur: got %0d want 0", current_grp);
    end
    checks++;
    if (count_evt !== 1'b0 || count_grp !== '0) begin
      errors++;
      $display("FAIL rst_evt: got %b/%0d want 0/0",
               count_evt, count_grp);
    end
    checks++;
    if (grp_count !== '0 || grp_sat !== '0) begin
      errors++;
      $display("FAIL rst_cnt: got %h/%b want 0/0",
               grp_count, grp_sat);
    end
    reset = 0;
  endtask

  task automatic test_defaults();
    int ws [6];
    int ns [6];
    ws = '{270, 0, 300, 0, 501, 1013};
    ns = '{3, 2, 3, 2, 3, 3};
    n_evt = 0;
    for (int i = 0; i < 6; i++) begin
      hold(ws[i], ns[i]);
    end
    checks++;
    if (current_grp !== GW'(4)) begin
      errors++;
      $display("FAIL def_cur1013: got %0d want 4", current_grp);
    end
    checks++;
    if (get_cnt(2) != 2 || get_cnt(3) != 1 || get_cnt(4) != 0) begin
      errors++;
      $display("FAIL def_counts: got g2=%0d g3=%0d g4=%0d want 2 1 0",
               get_cnt(2), get_cnt(3), get_cnt(4));
    end
    checks++;
    if (n_evt != 3) begin
      errors++;
      $display("FAIL def_nevt: got %0d want 3", n_evt);
    end
    hold(0, 2);
  endtask

  task automatic test_boundaries();
    int ws [6];
    int gs [6];
    ws = '{1, 250, 251, 2000, 2001, 4095};
    gs = '{1, 1, 2, 5, 6, 6};
    for (int i = 0; i < 6; i++) begin
      n_evt = 0; last_grp = -1;
      hold(ws[i], 3);
      checks++;
      if (n_evt != 1 || last_grp != gs[i]
          || int'(current_grp) != gs[i]) begin
        errors++;
        $display("FAIL bound_%0d: got n=%0d grp=%0d cur=%0d want 1 %0d",
                 ws[i], n_evt, last_grp, current_grp, gs[i]);
      end
      hold(0, 2);
    end
  endtask

  task automatic test_glitch();
    n_evt = 0;
    hold(600, 1);
    hold(0, 2);
    checks++;
    if (n_evt != 0) begin
      errors++;
      $display("FAIL glitch: got %0d counts want 0", n_evt);
    end
    hold(400, 1);
    hold(800, 1);
    checks++;
    if (count_evt !== 1'b0) begin
      errors++;
      $display("FAIL settle_early: got evt=%b want 0", count_evt);
    end
    hold(800, 1);
    checks++;
    if (count_evt !== 1'b1 || count_grp !== GW'(4)) begin
      errors++;
      $display("FAIL settle_cnt: got %b/%0d want 1/4",
               count_evt, count_grp);
    end
    n_evt = 0;
    hold(800, 2);
    checks++;
    if (n_evt != 0) begin
      errors++;
      $display("FAIL once: got %0d extra counts want 0", n_evt);
    end
    hold(0, 2);
  endtask

  task automatic test_reprogram();
    cfg_if.cfg_we = 1; cfg_if.cfg_idx = 4'd0;
    cfg_if.cfg_thresh = 12'd100;
    tick();
    cfg_if.cfg_we = 0;
    n_evt = 0; last_grp = -1;
    hold(150, 3);
    checks++;
    if (n_evt != 1 || last_grp != 2) begin
      errors++;
      $display("FAIL reprog150: got n=%0d grp=%0d want 1 2",
               n_evt, last_grp);
    end
    hold(0, 2);
    cfg_if.cfg_we = 1; cfg_if.cfg_idx = 4'd7;
    cfg_if.cfg_thresh = 12'd10;
    tick();
    cfg_if.cfg_we = 0;
    n_evt = 0; last_grp = -1;
    hold(90, 3);
    hold(0, 2);
    hold(1600, 3);
    checks++;
    if (n_evt != 2 || last_grp != 5) begin
      errors++;
      $display("FAIL reprog_oor: got n=%0d grp=%0d want 2 5",
               n_evt, last_grp);
    end
    hold(0, 2);
  endtask

  task automatic test_saturation();
    clear_counts = 1;
    tick();
    clear_counts = 0;
    checks++;
    if (grp_count !== '0 || grp_sat !== '0) begin
      errors++;
      $display("FAIL clear: got %h/%b want 0/0", grp_count, grp_sat);
    end
    repeat (4) begin
      hold(50, 2);
      hold(0, 1);
    end
    checks++;
    if (get_cnt(1) != 3 || grp_sat[0] !== 1'b1) begin
      errors++;
      $display("FAIL sat: got cnt=%0d sat=%b want 3 1",
               get_cnt(1), grp_sat[0]);
    end
    hold(50, 1);
    clear_counts = 1;
    hold(50, 1);
    clear_counts = 0;
    checks++;
    if (count_evt !== 1'b1 || get_cnt(1) != 1 || grp_sat[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_cnt: got evt=%b cnt=%0d sat=%b want 1 1 0",
               count_evt, get_cnt(1), grp_sat[0]);
    end
    hold(0, 2);
  endtask

  task automatic test_reset_mid();
    hold(700, 1);
    reset = 1;
    hold(700, 1);
    checks++;
    if (current_grp !== '0 || count_evt !== 1'b0 || count_grp !== '0
        || grp_count !== '0 || grp_sat !== '0) begin
      errors++;
      $display("FAIL mid_rst: got cur=%0d evt=%b cnt=%h sat=%b want 0",
               current_grp, count_evt, grp_count, grp_sat);
    end
    reset = 0;
    hold(700, 1);
    checks++;
    if (count_evt !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_early: got evt=%b want 0", count_evt);
    end
    hold(700, 1);
    checks++;
    if (count_evt !== 1'b1 || count_grp !== GW'(3) || get_cnt(3) != 1) begin
      errors++;
      $display("FAIL post_rst_cnt: got %b/%0d/%0d want 1/3/1",
               count_evt, count_grp, get_cnt(3));
    end
    hold(0, 2);
  endtask

  task automatic test_random();
    int w, len;
    logic [NG*CW-1:0] ev;
    logic [NG-1:0] es;
    for (int seg = 0; seg < 250; seg++) begin
      case ($urandom_range(0, 3))
        0: w = 0;
        1: w = $urandom_range(1, 4095);
        2: w = th_m[$urandom_range(0, NG - 2)]
               + $urandom_range(0, 2) - 1;
        default: w = $urandom_range(1, 300);
      endcase
      if (w < 0) w = 0;
      if (w > 4095) w = 4095;
      weight = W'(w);
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        reset = ($urandom_range(0, 99) == 0);
        clear_counts = ($urandom_range(0, 29) == 0);
        cfg_if.cfg_we = ($urandom_range(0, 19) == 0);
        cfg_if.cfg_idx = GW'($urandom_range(0, 7));
        cfg_if.cfg_thresh = W'($urandom_range(0, 4095));
        tick();
        for (int k = 1; k <= NG; k++) begin
          ev[(k-1)*CW +: CW] = CW'(cnt_m[k]);
          es[k-1] = sat_m[k];
        end
        checks++;
        if (int'(current_grp) !== exp_cur) begin
          errors++;
          $display("FAIL rnd_cur: got %0d want %0d",
                   current_grp, exp_cur);
        end
        checks++;
        if (count_evt !== exp_evt
            || (exp_evt && int'(count_grp) !== exp_grp)) begin
          errors++;
          $display("FAIL rnd_evt: got %b/%0d want %b/%0d",
                   count_evt, count_grp, exp_evt, exp_grp);
        end
        checks++;
        if (grp_count !== ev || grp_sat !== es) begin
          errors++;
          $display("FAIL rnd_cnt: got %h/%b want %h/%b",
                   grp_count, grp_sat, ev, es);
        end
      end
    end
    reset = 0; clear_counts = 0; cfg_if.cfg_we = 0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_boundaries();
    test_glitch();
    test_reprogram();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/package_sorter_param.md
Name: package_sorter_param

Overview:
Next-generation package sorter. Classifies a live scale weight into NUM_GRP weight groups using runtime-programmable thresholds. It counts each package once, after the weight has settled for SETTLE cycles, and keeps a saturating counter per group. It sits between the scale front-end and the status/display logic, replacing the fixed six-group sorter.

Parameters:
W_WIDTH, 12, weight bus width (unsigned)
NUM_GRP, 6, number of groups (2..9)
CNT_WIDTH, 8, per-group counter width
SETTLE, 2, consecutive sampled edges a nonzero weight must stay in one group before it is counted (>=1)
GRP_W, 4, width of group index (must hold NUM_GRP)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
weight  in  W_WIDTH  live scale reading; 0 = no package present
cfg_we  in  1  threshold write strobe
cfg_idx  in  GRP_W  threshold index 0..NUM_GRP-2 (upper bound of group idx+1)
cfg_thresh  in  W_WIDTH  threshold value written
clear_counts  in  1  zero all counters and saturation flags
current_grp  out  GRP_W  registered group of present weight; 0 = none
count_evt  out  1  one-cycle pulse when a package is counted
count_grp  out  GRP_W  group counted; valid with count_evt
grp_count  out  NUM_GRP*CNT_WIDTH  flattened counters; group k (1-based) at bits [k*CNT_WIDTH-1 -: CNT_WIDTH]
grp_sat  out  NUM_GRP  sticky per-group saturation flags, bit k-1 = group k

Behaviour:
- Reset: current_grp=0, count_evt=0, count_grp=0, all counters 0, grp_sat=0, FSM=IDLE. Thresholds load from the package defaults DEF_THRESH = {250,500,750,1500,2000,2500,3000,3500}, entries 0..NUM_GRP-2. Reset overrides every other input in the same cycle.
- Classification is combinational from weight and thresholds:
  - weight==0 -> group 0.
  - Otherwise, the lowest k with weight <= thresh[k-1].
  - Weight above every threshold -> group NUM_GRP.
  - Thresholds that are not monotonic are not checked; lowest-index match wins.
- current_grp <= classification every edge (1-cycle latency). It tracks the weight even after the package has been counted.
- FSM states: IDLE, SETTLING, COUNTED. A count action increments the counter of the classified group, pulses count_evt for one cycle and drives count_grp.
- IDLE, class!=0:
  - SETTLE==1 -> count this edge, go to COUNTED.
  - Otherwise -> go to SETTLING with stab_grp=class, stab_cnt=1.
- SETTLING:
  - class==0 -> IDLE, no count (glitch rejected).
  - class!=stab_grp -> stab_grp=class, stab_cnt=1, stay.
  - class==stab_grp and stab_cnt+1==SETTLE -> count stab_grp, go to COUNTED.
  - Otherwise stab_cnt+1.
- COUNTED: class==0 -> IDLE. Any other weight change, including a group change, counts nothing (one count per object).
- Counters saturate at 2^CNT_WIDTH-1. An increment attempted at max leaves the count unchanged and sets grp_sat[k-1].
- clear_counts: all counters and grp_sat go to 0 on the next edge. A count in the same cycle is applied after the clear, so that counter reads 1. FSM state is unaffected.
- cfg_we: thresh[cfg_idx] <= cfg_thresh and is used for classification from the next cycle. Writes with cfg_idx > NUM_GRP-2 are ignored. A write during SETTLING may change the class and restart settling.
- Reset mid-SETTLING or mid-COUNTED returns to IDLE. A weight held across the reset is treated as a new object once reset drops.

Decomposition:
- Package pkg_sorter: DEF_THRESH array, the FSM state encoding, and a function returning the group index for a weight and threshold array.
- One sub-module, sorter_grp_counter: a saturating counter with increment, clear and sticky sat flag, instantiated NUM_GRP times in a generate loop.

Test Plan:
1. Defaults, SETTLE=2: reset; 270 for 3 cycles, 0 for 2, 300 for 3, 0 for 2, 501 for 3, 1013 for 3 -> Grp2=2, Grp3=1, Grp4=0; current_grp=4 during 1013; exactly 3 count_evt pulses.
2. Boundaries: weights 1, 250, 251, 2000, 2001, 4095, each for 3 cycles and separated by zeros -> groups 1, 1, 2, 5, 6, 6.
3. Glitch and settling: 600 for 1 cycle then 0 -> no count. 400 then 800 on consecutive cycles, then 800 held -> one count in group 4 only, 2 edges after 800 first appears.
4. Reprogram: write idx0=100; then 150 for 3 cycles -> counted in group 2. Write idx=7 (out of range) -> thresholds unchanged.
5. Saturation and clear, CNT_WIDTH=2: 4 packages in group 1 -> count stays 3 and grp_sat[0]=1. clear_counts asserted in the same cycle as a group-1 count event -> count=1, grp_sat[0]=0.
6. Reset mid-operation: reset asserted during SETTLING with 700 held -> all outputs 0. Reset released with 700 still held -> counted as a new object after SETTLE edges.
